multicycle_shift_block: RTL and testbench
=========================================

// Module: multicycle_shift_block
// PURPOSE
//  Iterative right-shift/rotate engine for the ALU; shifts at most STEP_WIDTH bits per clock.
//  Sits beside the combinational shift path for area-constrained configurations.
//  Supplies result and zf/cf/of/pf/sf flags over a valid/ready handshake.
//  Adds over the single-cycle shifter: parametrised step size, handshake, reserved-op flag.
// PARAMETERS
//  WORD_WIDTH  32  operand/result width; >= 4, power of two
//  STEP_WIDTH  4   max bits shifted per SHIFT cycle; power of two, 1..WORD_WIDTH
//  AMT_WIDTH   $clog2(WORD_WIDTH)  derived; shift-amount width; never overridden
// PORTS
//  clk_i    in   1             clock, all state on rising edge
//  rst_i    in   1             synchronous, active-high reset
//  valid_i  in   1             request valid
//  ready_o  out  1             block can accept a request
//  op_i     in   3             0 SHR, 1 SAR, 2 ROR, 3 RCR, 4 SHRD (funnel), 5-7 reserved
//  a_i      in   WORD_WIDTH    operand to shift
//  b_i      in   WORD_WIDTH    shift amount; only b_i[AMT_WIDTH-1:0] used
//  c_i      in   WORD_WIDTH-1  SHRD fill bits, shifted in above a_i
//  cf_i     in   1             carry in (RCR ring bit; passthrough when amount = 0)
//  valid_o  out  1             result/flags valid
//  ready_i  in   1             consumer takes result
//  r_o      out  WORD_WIDTH    result
//  cf_o/zf_o/of_o/pf_o/sf_o  out  1 each  carry, zero, overflow, parity, sign
//  ill_o    out  1             reserved opcode was issued
// BEHAVIOUR
//  Reset: state IDLE; ready_o=1, valid_o=0; r_o, all flags and ill_o = 0. Reset mid-op discards it.
//  FSM IDLE -> SHIFT -> DONE -> IDLE:
//   IDLE: ready_o=1. Accept when valid_i&&ready_o; latch op, a, c, cf, amt = b_i[AMT_WIDTH-1:0].
//    amt==0 or reserved op -> DONE; else -> SHIFT.
//   SHIFT: ready_o=0; each cycle shift by k = min(rem, STEP_WIDTH), rem -= k; -> DONE when rem==k.
//   DONE: valid_o=1; r_o and flags held stable until ready_i; valid_o&&ready_i -> IDLE.
//  ready_o is high only in IDLE; no accept in DONE; max throughput one op per latency+1 cycles.
//  Latency, acceptance to valid_o: 1 + ceil(amt/STEP_WIDTH) cycles (1 when amt == 0).
//  Inputs are sampled only at acceptance; later changes are ignored.
//  Ops, amt n in 1..WORD_WIDTH-1:
//   SHR: zero fill. SAR: sign fill. ROR: rotate a. RCR: rotate the WORD_WIDTH+1 ring {cf, a}.
//   SHRD: r = ({c, a} >> n)[WORD_WIDTH-1:0].
//   cf_o = last bit shifted out of bit 0 (a[n-1] for SHR/SAR/SHRD/ROR); RCR: ring carry.
//  amt==0: r_o = a, cf_o = cf_i.
//  Reserved op: r_o = a, cf_o = cf_i, ill_o = 1; ill_o = 0 for all legal ops.
//  Flags derive from the final r_o:
//   zf = ~|r, pf = r[0], sf = r[MSB], of = sf ^ a[MSB] (a = latched operand).
//  Registered outputs; no combinational path from any input to any output.
// STRUCTURE
//  alu_pkg:
//   shift_op_e {SHR, SAR, ROR, RCR, SHRD}
//   shift_state_e {IDLE, SHIFT, DONE}
//   SHIFT_OP_WIDTH = 3
//  Sub-module shift_step_unit: combinational single step.
//   Inputs: op, data, fill (WORD_WIDTH-1), cf, k (0..STEP_WIDTH).
//   Outputs: next data, next fill, next cf.
//  Top holds FSM, working regs data_q/fill_q/cf_q/rem_q, flag logic.
// TESTING
//  All vectors use WORD_WIDTH=8, STEP_WIDTH=2.
//  1 SHR a=0xB4 b=3 -> valid_o 3 cycles after accept; r=0x16 cf=1 zf=0 sf=0 of=1 pf=0.
//  2 SAR a=0x81 b=7 -> 5-cycle latency; r=0xFF cf=0 sf=1 of=0.
//    RCR a=0x01 cf_i=1 b=1 -> r=0x80 cf=1.
//  3 SHRD a=0x0F c=0x55 b=4 -> r=0x50 cf=1.
//    SHR a=0x01 b=1 -> r=0x00 zf=1 cf=1.
//  4 b=0x08 (amt 0), cf_i=1 -> valid_o 1 cycle after accept; r=a, cf=1.
//    op=6 -> r=a, ill_o=1, 1-cycle latency.
//  5 Backpressure: ready_i=0 for 5 cycles in DONE.
//    r_o/flags stable, ready_o=0, new valid_i ignored; ready_i=1 -> IDLE next cycle.
//  6 rst_i pulsed during SHIFT -> next cycle ready_o=1, valid_o=0, r_o=0.
//    Next request completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and state encodings for the iterative shift engine.
package alu_pkg;

  localparam int unsigned SHIFT_OP_WIDTH = 3;

  typedef enum logic [SHIFT_OP_WIDTH-1:0] {
    SHR  = 3'd0,
    SAR  = 3'd1,
    ROR  = 3'd2,
    RCR  = 3'd3,
    SHRD = 3'd4
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

endpackage

// File: rtl/shift_step_unit.sv
// Combinational single step: shifts data right by k (0..STEP_WIDTH) bits for the given op.
module shift_step_unit
  import alu_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned STEP_WIDTH = 4,
  parameter int unsigned AMT_WIDTH  = 5
) (
  input  logic [SHIFT_OP_WIDTH-1:0] op_i,
  input  logic [WORD_WIDTH-1:0]     data_i,
  input  logic [WORD_WIDTH-2:0]     fill_i,
  input  logic                      cf_i,
  input  logic [AMT_WIDTH-1:0]      k_i,
  output logic [WORD_WIDTH-1:0]     data_o,
  output logic [WORD_WIDTH-2:0]     fill_o,
  output logic                      cf_o
);

  logic msb_in;

  // Unrolled chain of one-bit steps; only the first k are applied.
  always_comb begin
    data_o = data_i;
    fill_o = fill_i;
    cf_o   = cf_i;
    msb_in = 1'b0;
    for (int unsigned i = 0; i < STEP_WIDTH; i++) begin
      if (AMT_WIDTH'(i) < k_i) begin
        msb_in = 1'b0;
        case (op_i)
          SHR:     msb_in = 1'b0;
          SAR:     msb_in = data_o[WORD_WIDTH-1];
          ROR:     msb_in = data_o[0];
          RCR:     msb_in = cf_o;
          SHRD:    msb_in = fill_o[0];
          default: msb_in = 1'b0;
        endcase
        cf_o   = data_o[0];
        data_o = {msb_in, data_o[WORD_WIDTH-1:1]};
        if (op_i == SHRD) begin
          fill_o = {1'b0, fill_o[WORD_WIDTH-2:1]};
        end
      end
    end
  end

endmodule

// File: rtl/multicycle_shift_block.sv
// Iterative right-shift/rotate engine with valid/ready handshake and registered result/flags.
module multicycle_shift_block
  import alu_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32,
  parameter int unsigned STEP_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [SHIFT_OP_WIDTH-1:0] op_i,
  input  logic [WORD_WIDTH-1:0]     a_i,
  input  logic [WORD_WIDTH-1:0]     b_i,
  input  logic [WORD_WIDTH-2:0]     c_i,
  input  logic                      cf_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [WORD_WIDTH-1:0]     r_o,
  output logic                      cf_o,
  output logic                      zf_o,
  output logic                      of_o,
  output logic                      pf_o,
  output logic                      sf_o,
  output logic                      ill_o
);

  localparam int unsigned AMT_WIDTH = $clog2(WORD_WIDTH);
  localparam int unsigned AMT_W1    = AMT_WIDTH + 1;

  shift_state_e state_q, state_d;
  logic [SHIFT_OP_WIDTH-1:0] op_q, op_d;
  logic [WORD_WIDTH-1:0]     data_q, data_d;
  logic [WORD_WIDTH-2:0]     fill_q, fill_d;
  logic                      ring_cf_q, ring_cf_d;
  logic [AMT_WIDTH-1:0]      rem_q, rem_d;
  logic                      a_msb_q, a_msb_d;

  logic                      ready_q, ready_d;
  logic                      valid_q, valid_d;
  logic [WORD_WIDTH-1:0]     r_q, r_d;
  logic                      cf_out_q, cf_out_d;
  logic                      zf_q, zf_d, of_q, of_d, pf_q, pf_d, sf_q, sf_d;
  logic                      ill_q, ill_d;

  logic [AMT_WIDTH-1:0]      step_k;
  logic [WORD_WIDTH-1:0]     step_data;
  logic [WORD_WIDTH-2:0]     step_fill;
  logic                      step_cf;

  logic                      load_res;
  logic [WORD_WIDTH-1:0]     res_c;
  logic                      res_cf_c, res_ill_c, res_amsb_c;

  logic unused_b;
  assign unused_b = ^b_i[WORD_WIDTH-1:AMT_WIDTH];

  always_comb begin
    if ({1'b0, rem_q} < AMT_W1'(STEP_WIDTH)) step_k = rem_q;
    else                                     step_k = AMT_WIDTH'(STEP_WIDTH);
  end

  shift_step_unit #(
    .WORD_WIDTH(WORD_WIDTH),
    .STEP_WIDTH(STEP_WIDTH),
    .AMT_WIDTH (AMT_WIDTH)
  ) u_step (
    .op_i  (op_q),
    .data_i(data_q),
    .fill_i(fill_q),
    .cf_i  (ring_cf_q),
    .k_i   (step_k),
    .data_o(step_data),
    .fill_o(step_fill),
    .cf_o  (step_cf)
  );

  // Next-state and working-register update; load_res marks entry into DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    fill_d     = fill_q;
    ring_cf_d  = ring_cf_q;
    rem_d      = rem_q;
    a_msb_d    = a_msb_q;
    load_res   = 1'b0;
    res_c      = data_q;
    res_cf_c   = ring_cf_q;
    res_ill_c  = 1'b0;
    res_amsb_c = a_msb_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          op_d      = op_i;
          data_d    = a_i;
          fill_d    = c_i;
          ring_cf_d = cf_i;
          rem_d     = b_i[AMT_WIDTH-1:0];
          a_msb_d   = a_i[WORD_WIDTH-1];
          if (b_i[AMT_WIDTH-1:0] == '0 || op_i > SHRD) begin
            state_d    = DONE;
            load_res   = 1'b1;
            res_c      = a_i;
            res_cf_c   = cf_i;
            res_ill_c  = (op_i > SHRD);
            res_amsb_c = a_i[WORD_WIDTH-1];
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d    = step_data;
        fill_d    = step_fill;
        ring_cf_d = step_cf;
        rem_d     = rem_q - step_k;
        if (rem_q == step_k) begin
          state_d    = DONE;
          load_res   = 1'b1;
          res_c      = step_data;
          res_cf_c   = step_cf;
          res_amsb_c = a_msb_q;
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output registers: results and flags captured once, held until the next completion.
  always_comb begin
    ready_d  = (state_d == IDLE);
    valid_d  = (state_d == DONE);
    r_d      = r_q;
    cf_out_d = cf_out_q;
    zf_d     = zf_q;
    of_d     = of_q;
    pf_d     = pf_q;
    sf_d     = sf_q;
    ill_d    = ill_q;
    if (load_res) begin
      r_d      = res_c;
      cf_out_d = res_cf_c;
      zf_d     = ~|res_c;
      pf_d     = res_c[0];
      sf_d     = res_c[WORD_WIDTH-1];
      of_d     = res_c[WORD_WIDTH-1] ^ res_amsb_c;
      ill_d    = res_ill_c;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= '0;
      data_q    <= '0;
      fill_q    <= '0;
      ring_cf_q <= 1'b0;
      rem_q     <= '0;
      a_msb_q   <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
      r_q       <= '0;
      cf_out_q  <= 1'b0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
      pf_q      <= 1'b0;
      sf_q      <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      data_q    <= data_d;
      fill_q    <= fill_d;
      ring_cf_q <= ring_cf_d;
      rem_q     <= rem_d;
      a_msb_q   <= a_msb_d;
      ready_q   <= ready_d;
      valid_q   <= valid_d;
      r_q       <= r_d;
      cf_out_q  <= cf_out_d;
      zf_q      <= zf_d;
      of_q      <= of_d;
      pf_q      <= pf_d;
      sf_q      <= sf_d;
      ill_q     <= ill_d;
    end
  end

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign r_o     = r_q;
  assign cf_o    = cf_out_q;
  assign zf_o    = zf_q;
  assign of_o    = of_q;
  assign pf_o    = pf_q;
  assign sf_o    = sf_q;
  assign ill_o   = ill_q;

endmodule

// File: tb/tb_multicycle_shift_block.sv
// Randomized bench for multicycle_shift_block (WORD_WIDTH=8, STEP_WIDTH=2) against an arithmetic model.
module tb_multicycle_shift_block;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [2:0] op_i = '0;
  logic [7:0] a_i = '0;
  logic [7:0] b_i = '0;
  logic [6:0] c_i = '0;
  logic       cf_i = 1'b0;
  logic       valid_o;
  logic       ready_i = 1'b0;
  logic [7:0] r_o;
  logic       cf_o, zf_o, of_o, pf_o, sf_o, ill_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  multicycle_shift_block #(.WORD_WIDTH(8), .STEP_WIDTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .op_i(op_i), .a_i(a_i), .b_i(b_i), .c_i(c_i), .cf_i(cf_i),
    .valid_o(valid_o), .ready_i(ready_i), .r_o(r_o),
    .cf_o(cf_o), .zf_o(zf_o), .of_o(of_o), .pf_o(pf_o), .sf_o(sf_o), .ill_o(ill_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Flags packed as {cf, zf, of, pf, sf, ill}.
  task automatic model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [6:0] c, input logic cf,
                       output logic [7:0] r, output logic [5:0] fl, output int lat);
    int n;
    logic [14:0] ca;
    logic [8:0]  ring, rot;
    logic        co;
    n  = int'(b[2:0]);
    ca = {c, a};
    r  = a;
    co = cf;
    if (op <= 3'd4 && n != 0) begin
      co = ca[n-1];
      case (op)
        3'd0: r = a >> n;
        3'd1: r = 8'($signed(a) >>> n);
        3'd2: r = 8'((a >> n) | (a << (8 - n)));
        3'd3: begin
          ring = {cf, a};
          rot  = 9'((ring >> n) | (ring << (9 - n)));
          r    = rot[7:0];
          co   = rot[8];
        end
        default: r = 8'(ca >> n);
      endcase
    end
    lat = (op > 3'd4 || n == 0) ? 1 : 1 + (n + 1) / 2;
    fl  = {co, (r == 8'h00), r[7] ^ a[7], r[0], r[7], (op > 3'd4)};
  endtask

  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [6:0] c, input logic cf, input int bp);
    logic [7:0] er;
    logic [5:0] efl;
    int         elat, lat;
    model(op, a, b, c, cf, er, efl, elat);
    @(negedge clk_i);
    check("ready_idle", 32'(ready_o), 32'd1);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; c_i = c; cf_i = cf;
    @(negedge clk_i);
    valid_i = 1'b0;
    op_i = 3'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
    c_i = 7'($urandom); cf_i = 1'($urandom);
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("result", 32'(r_o), 32'(er));
    check("flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o, ill_o}), 32'(efl));
    check("ready_busy", 32'(ready_o), 32'd0);
    for (int i = 0; i < bp; i++) begin
      valid_i = 1'b1; op_i = 3'($urandom); a_i = 8'($urandom); b_i = 8'($urandom);
      @(negedge clk_i);
      check("hold_result", 32'(r_o), 32'(er));
      check("hold_flags", 32'({cf_o, zf_o, of_o, pf_o, sf_o, ill_o}), 32'(efl));
      check("hold_hs", 32'({valid_o, ready_o}), 32'b10);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    check("back_idle", 32'({valid_o, ready_o}), 32'b01);
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    check("reset_hs", 32'({valid_o, ready_o}), 32'b01);
    check("reset_out", 32'({r_o, cf_o, zf_o, of_o, pf_o, sf_o, ill_o}), 32'd0);

    do_op(3'd0, 8'hB4, 8'd3, 7'h00, 1'b0, 0);
    do_op(3'd1, 8'h81, 8'd7, 7'h00, 1'b0, 0);
    do_op(3'd3, 8'h01, 8'd1, 7'h00, 1'b1, 0);
    do_op(3'd4, 8'h0F, 8'd4, 7'h55, 1'b0, 0);
    do_op(3'd0, 8'h01, 8'd1, 7'h00, 1'b0, 0);
    do_op(3'd2, 8'h96, 8'h08, 7'h00, 1'b1, 0);
    do_op(3'd6, 8'h5A, 8'd3, 7'h12, 1'b0, 0);
    do_op(3'd2, 8'hC3, 8'd5, 7'h00, 1'b0, 5);

    // Reset in the middle of a SHIFT sequence.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 3'd0; a_i = 8'hFF; b_i = 8'd7; c_i = '0; cf_i = 1'b0;
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check("midrst_hs", 32'({valid_o, ready_o}), 32'b01);
    check("midrst_r", 32'(r_o), 32'd0);
    do_op(3'd1, 8'hA0, 8'd6, 7'h00, 1'b0, 0);

    for (int t = 0; t < 150; t++) begin
      logic [2:0] op;
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      do_op(op, 8'($urandom), 8'($urandom), 7'($urandom), 1'($urandom), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
